// File: rtl/key_event_gen.sv
// Purpose: debounce active-low push buttons into clean level, press, release and auto-repeat events.
// Latency: a key change sampled at edge k is reported after edge k+DEBOUNCE_CYCLES+2; all outputs registered.
// Backpressure: none; pulses last one cycle and consumers must take them when they appear.
module key_event_gen #(
    parameter int NUM_KEYS        = 4,
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000,
    parameter int CNT_W           = 28
) (
    input  logic                CLOCK_50,
    input  logic                RESET_N,
    input  logic [NUM_KEYS-1:0] KEY,
    input  logic                REPEAT_EN,
    output logic [NUM_KEYS-1:0] KEY_LEVEL,
    output logic [NUM_KEYS-1:0] PRESS_PULSE,
    output logic [NUM_KEYS-1:0] RELEASE_PULSE,
    output logic [NUM_KEYS-1:0] REPEAT_PULSE,
    output logic [7:0]          EVENT_COUNT
);

    typedef enum logic [1:0] {UP, DEB_DN, HELD, DEB_UP} key_state_t;

    localparam logic [CNT_W-1:0] DC_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RC_FIRST   = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RC_PERIODC = CNT_W'(REPEAT_PERIOD - 1);

    logic [NUM_KEYS-1:0] sync1;
    logic [NUM_KEYS-1:0] sync2;
    logic [NUM_KEYS-1:0] level_nxt_v;
    logic [NUM_KEYS-1:0] press_nxt_v;
    logic [NUM_KEYS-1:0] release_nxt_v;
    logic [NUM_KEYS-1:0] repeat_nxt_v;
    logic [7:0]          ev_inc;

    // Two-flop synchroniser; resets to the released (high) level so no phantom press follows reset.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= KEY;
            sync2 <= sync1;
        end
    end

    for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
        key_state_t       state, state_nxt;
        logic [CNT_W-1:0] dc, dc_nxt;
        logic [CNT_W-1:0] rc, rc_nxt;
        logic             first_tick, first_tick_nxt;
        logic             level_nxt, press_nxt, release_nxt, repeat_nxt;
        logic             s;

        assign s = sync2[g];

        // Per-key state and counters; rc/first_tick persist through DEB_UP so a release glitch resumes the repeat timing.
        always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
            if (!RESET_N) begin
                state      <= UP;
                dc         <= '0;
                rc         <= '0;
                first_tick <= 1'b1;
            end else begin
                state      <= state_nxt;
                dc         <= dc_nxt;
                rc         <= rc_nxt;
                first_tick <= first_tick_nxt;
            end
        end

        // Debounce/repeat transitions; the *_nxt pulses land in the output registers on the same edge as the state change.
        always_comb begin
            state_nxt      = state;
            dc_nxt         = dc;
            rc_nxt         = rc;
            first_tick_nxt = first_tick;
            level_nxt      = KEY_LEVEL[g];
            press_nxt      = 1'b0;
            release_nxt    = 1'b0;
            repeat_nxt     = 1'b0;
            case (state)
                UP: begin
                    if (!s) begin
                        state_nxt = DEB_DN;
                        dc_nxt    = '0;
                    end
                end
                DEB_DN: begin
                    if (s) begin
                        state_nxt = UP;
                    end else if (dc == DC_LAST) begin
                        state_nxt      = HELD;
                        press_nxt      = 1'b1;
                        level_nxt      = 1'b1;
                        rc_nxt         = '0;
                        first_tick_nxt = 1'b1;
                    end else begin
                        dc_nxt = dc + 1'b1;
                    end
                end
                HELD: begin
                    if (s) begin
                        state_nxt = DEB_UP;
                        dc_nxt    = '0;
                    end else if (!REPEAT_EN) begin
                        rc_nxt         = '0;
                        first_tick_nxt = 1'b1;
                    end else if (rc == (first_tick ? RC_FIRST : RC_PERIODC)) begin
                        repeat_nxt     = 1'b1;
                        rc_nxt         = '0;
                        first_tick_nxt = 1'b0;
                    end else begin
                        rc_nxt = rc + 1'b1;
                    end
                end
                DEB_UP: begin
                    if (!s) begin
                        state_nxt = HELD;
                    end else if (dc == DC_LAST) begin
                        state_nxt      = UP;
                        release_nxt    = 1'b1;
                        level_nxt      = 1'b0;
                        rc_nxt         = '0;
                        first_tick_nxt = 1'b1;
                    end else begin
                        dc_nxt = dc + 1'b1;
                    end
                end
                default: state_nxt = UP;
            endcase
        end

        assign level_nxt_v[g]   = level_nxt;
        assign press_nxt_v[g]   = press_nxt;
        assign release_nxt_v[g] = release_nxt;
        assign repeat_nxt_v[g]  = repeat_nxt;
    end

    // Count of press and repeat pulses currently on the outputs, across all keys.
    always_comb begin
        ev_inc = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            ev_inc = ev_inc + {7'd0, PRESS_PULSE[i] | REPEAT_PULSE[i]};
        end
    end

    // Registered outputs and the free-running modulo-256 event counter.
    always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
        if (!RESET_N) begin
            KEY_LEVEL     <= '0;
            PRESS_PULSE   <= '0;
            RELEASE_PULSE <= '0;
            REPEAT_PULSE  <= '0;
            EVENT_COUNT   <= '0;
        end else begin
            KEY_LEVEL     <= level_nxt_v;
            PRESS_PULSE   <= press_nxt_v;
            RELEASE_PULSE <= release_nxt_v;
            REPEAT_PULSE  <= repeat_nxt_v;
            EVENT_COUNT   <= EVENT_COUNT + ev_inc;
        end
    end

endmodule

// File: doc/key_event_gen.md
Name: key_event_gen

Overview:
- Turns raw, bouncy, active-low push-button inputs (KEY) into clean per-key events: debounced level, one-cycle press pulse, one-cycle release pulse, optional auto-repeat pulse.
- It is the producing end of the key-event interface. LED and control logic downstream consume these pulses with their own edge/pulse detection, so they never have to synthesise key edges from counter bits.
- It also keeps a running 8-bit event count for on-board display.

Parameters:
- NUM_KEYS, 4, number of independent key channels.
- DEBOUNCE_CYCLES, 1000000, cycles a new level must be stable before it is accepted (20 ms at 50 MHz); minimum 2.
- REPEAT_DELAY, 25000000, cycles from press pulse to first repeat pulse (500 ms).
- REPEAT_PERIOD, 5000000, cycles between subsequent repeat pulses (100 ms).
- CNT_W, 28, width of the debounce and repeat counters; must hold max(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD).

Ports:
- CLOCK_50 in 1: system clock, all logic on its rising edge.
- RESET_N in 1: asynchronous, active-low reset.
- KEY in NUM_KEYS: raw buttons; 0 = pressed; asynchronous to CLOCK_50.
- REPEAT_EN in 1: 1 enables auto-repeat on all keys.
- KEY_LEVEL out NUM_KEYS: debounced state; 1 = pressed.
- PRESS_PULSE out NUM_KEYS: one-cycle high on accepted press.
- RELEASE_PULSE out NUM_KEYS: one-cycle high on accepted release.
- REPEAT_PULSE out NUM_KEYS: one-cycle high per auto-repeat tick.
- EVENT_COUNT out 8: total press and repeat pulses, modulo 256.

Behaviour:
- Clock and reset: one clock domain. RESET_N is asynchronous, active-low. Assertion is immediate; deassertion takes effect at the next clock edge.
- Reset values:
  - synchronisers = 1 (released);
  - every FSM = UP;
  - all counters = 0;
  - KEY_LEVEL = 0, PRESS_PULSE = 0, RELEASE_PULSE = 0, REPEAT_PULSE = 0, EVENT_COUNT = 0.
- Input synchroniser: per key, a 2-flop synchroniser; s = KEY value sampled two edges earlier. All outputs are registered.
- Per-key FSM, with debounce counter dc and repeat counter rc:
  - UP: s=0 -> DEB_DN, dc=0.
  - DEB_DN:
    - s=1 -> UP (bounce, no output).
    - else if dc==DEBOUNCE_CYCLES-1 -> HELD, PRESS_PULSE=1 for that key next cycle, KEY_LEVEL=1, rc=0.
    - else dc++.
  - HELD:
    - s=1 -> DEB_UP, dc=0, rc frozen.
    - else if REPEAT_EN, rc counts; when rc reaches REPEAT_DELAY-1 (first tick) or REPEAT_PERIOD-1 (later ticks), REPEAT_PULSE=1 and rc=0.
    - If REPEAT_EN=0, rc holds at 0 and no repeats.
  - DEB_UP:
    - s=0 -> HELD, no pulse, rc resumes from its frozen value.
    - else if dc==DEBOUNCE_CYCLES-1 -> UP, RELEASE_PULSE=1, KEY_LEVEL=0, rc and first-tick flag cleared.
    - else dc++.
- Latency: KEY low first sampled at edge k and held -> PRESS_PULSE high for exactly the cycle after edge k+DEBOUNCE_CYCLES+2. Release latency is symmetric.
- Pulses are never high two consecutive cycles on the same key.
- PRESS_PULSE, RELEASE_PULSE and REPEAT_PULSE are mutually exclusive per key.
- EVENT_COUNT adds popcount(PRESS_PULSE | REPEAT_PULSE) across all keys each cycle. Simultaneous events on multiple keys add their full count in one cycle. Wraps 255 -> 0 with no saturation or flag.
- REPEAT_EN falling mid-hold: rc clears, and the next enable restarts with REPEAT_DELAY.
- Keys are fully independent; simultaneous presses produce simultaneous pulses.
- Reset mid-press: all state is lost and no release pulse is emitted. A key still held after reset is re-debounced and produces a fresh PRESS_PULSE.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_DELAY=20, REPEAT_PERIOD=8, REPEAT_EN=0 unless noted):
- Clean press: KEY[0] low from edge 10 -> PRESS_PULSE[0] high only after edge 16; KEY_LEVEL[0]=1 from then; EVENT_COUNT=1.
- Bounce: KEY[1] low 3 cycles, high 2, low held -> exactly one PRESS_PULSE[1], measured from start of the final low; no release pulse.
- Release with glitch: held key goes high 2 cycles, low, then high held -> no pulse during the glitch; one RELEASE_PULSE 6 cycles after the final rise; KEY_LEVEL drops the same cycle.
- Auto-repeat: REPEAT_EN=1, KEY[2] held 60 cycles after press pulse -> REPEAT_PULSE[2] at +20, +28, +36, +44, +52; EVENT_COUNT=6.
- Simultaneous/wrap: EVENT_COUNT preloaded to 254 by presses; KEY[3:0] all pressed on the same edge -> four PRESS_PULSE bits in one cycle; EVENT_COUNT 254 -> 2.
- Async reset: RESET_N low mid-hold between clock edges -> all outputs 0 immediately; on release with key still low, one new PRESS_PULSE after DEBOUNCE_CYCLES+3 edges.
